// File: rtl/ddr2_sys_ddr2_dmaster_st_arbiter_pkg.sv
// Shared definitions for the dmaster Avalon-ST arbiters: controller state
// encoding and the channel-tag width derivation.
package ddr2_sys_ddr2_dmaster_st_arbiter_pkg;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } arb_state_t;

   // Channel tag width: max(1, clog2(n)).
   function automatic int chan_w(input int n);
      int w;
      w = 1;
      while ((1 << w) < n) w++;
      return w;
   endfunction

endpackage

// File: rtl/ddr2_sys_ddr2_dmaster_rr_pick.sv
// Combinational round-robin pick: first set request found searching upward
// from ptr with wrap-around. ptr must be below N.
module ddr2_sys_ddr2_dmaster_rr_pick #(
   parameter int N     = 2,
   parameter int PTR_W = 1
) (
   input  logic [N-1:0]     req,
   input  logic [PTR_W-1:0] ptr,
   output logic             found,
   output logic [PTR_W-1:0] winner
);

   logic [2*N-1:0] dbl;
   logic [N-1:0]   rot;
   int             sum;

   // Rotating the doubled vector puts the search start at bit 0.
   assign dbl = {req, req} >> ptr;
   assign rot = dbl[N-1:0];

   always_comb begin
      found  = 1'b0;
      winner = '0;
      sum    = 0;
      for (int j = 0; j < N; j++) begin
         if (!found && rot[j]) begin
            found = 1'b1;
            sum   = int'(ptr) + j;
            if (sum >= N) sum = sum - N;
            winner = PTR_W'(sum);
         end
      end
   end

endmodule

// File: rtl/ddr2_sys_ddr2_dmaster_st_arbiter.sv
// Packet-aware round-robin arbiter merging NUM_IN byte streams into the
// single dmaster byte stream through one registered output stage.
module ddr2_sys_ddr2_dmaster_st_arbiter
   import ddr2_sys_ddr2_dmaster_st_arbiter_pkg::*;
#(
   parameter int NUM_IN = 2,
   parameter int CHAN_W = chan_w(NUM_IN)
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [NUM_IN-1:0]   in_valid,
   input  logic [8*NUM_IN-1:0] in_data,
   input  logic [NUM_IN-1:0]   in_sop,
   input  logic [NUM_IN-1:0]   in_eop,
   output logic [NUM_IN-1:0]   in_ready,
   output logic                out_valid,
   output logic [7:0]          out_data,
   output logic                out_sop,
   output logic                out_eop,
   output logic [CHAN_W-1:0]   out_channel,
   input  logic                out_ready,
   output logic                proto_err,
   output logic                dbg_state
);

   // Handshake: a beat moves on a clock edge where valid and ready are both
   // high; valid never waits on ready, and a source holds its beat until taken.

   arb_state_t              state, state_nxt;
   logic [CHAN_W-1:0]       grant, grant_nxt;
   logic [CHAN_W-1:0]       rr_ptr, rr_ptr_nxt;
   logic                    first_beat, first_beat_nxt;
   logic                    err_set;
   logic                    found;
   logic [CHAN_W-1:0]       winner;
   logic                    g_valid, g_sop, g_eop;
   logic [7:0]              g_data;
   logic [NUM_IN-1:0]       gsel;
   logic                    can_load;
   logic                    xfer;

   ddr2_sys_ddr2_dmaster_rr_pick #(
      .N     (NUM_IN),
      .PTR_W (CHAN_W)
   ) u_pick (
      .req    (in_valid & in_sop),
      .ptr    (rr_ptr),
      .found  (found),
      .winner (winner)
   );

   always_comb begin
      g_valid = 1'b0;
      g_sop   = 1'b0;
      g_eop   = 1'b0;
      g_data  = '0;
      gsel    = '0;
      for (int i = 0; i < NUM_IN; i++) begin
         if (grant == CHAN_W'(i)) begin
            g_valid = in_valid[i];
            g_sop   = in_sop[i];
            g_eop   = in_eop[i];
            g_data  = in_data[8*i +: 8];
            gsel[i] = 1'b1;
         end
      end
   end

   // The output register can take a beat when empty or draining this cycle.
   assign can_load  = !out_valid || out_ready;
   assign in_ready  = (state == ST_LOCKED && can_load) ? gsel : '0;
   assign xfer      = (state == ST_LOCKED) && g_valid && can_load;
   assign dbg_state = state;

   always_comb begin
      state_nxt      = state;
      grant_nxt      = grant;
      rr_ptr_nxt     = rr_ptr;
      first_beat_nxt = first_beat;
      err_set        = 1'b0;
      case (state)
         ST_IDLE: begin
            if (|(in_valid & ~in_sop)) err_set = 1'b1;
            if (found) begin
               state_nxt      = ST_LOCKED;
               grant_nxt      = winner;
               first_beat_nxt = 1'b1;
            end
         end
         ST_LOCKED: begin
            if (xfer) begin
               first_beat_nxt = 1'b0;
               if (g_sop && !first_beat) err_set = 1'b1;
               if (g_eop) begin
                  state_nxt  = ST_IDLE;
                  rr_ptr_nxt = (grant == CHAN_W'(NUM_IN-1)) ? '0 : grant + CHAN_W'(1);
               end
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= ST_IDLE;
         grant      <= '0;
         rr_ptr     <= '0;
         first_beat <= 1'b0;
         proto_err  <= 1'b0;
      end else begin
         state      <= state_nxt;
         grant      <= grant_nxt;
         rr_ptr     <= rr_ptr_nxt;
         first_beat <= first_beat_nxt;
         proto_err  <= proto_err | err_set;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_valid   <= 1'b0;
         out_data    <= '0;
         out_sop     <= 1'b0;
         out_eop     <= 1'b0;
         out_channel <= '0;
      end else if (xfer) begin
         out_valid   <= 1'b1;
         out_data    <= g_data;
         out_sop     <= g_sop;
         out_eop     <= g_eop;
         out_channel <= grant;
      end else if (out_ready) begin
         out_valid   <= 1'b0;
      end
   end

endmodule

// File: tb/tb_ddr2_sys_ddr2_dmaster_st_arbiter.sv
// Bench for the dmaster stream arbiter: per-source beat queues feed the DUT,
// an expected-beat queue is checked against every accepted output beat.
module tb_ddr2_sys_ddr2_dmaster_st_arbiter;
   import ddr2_sys_ddr2_dmaster_st_arbiter_pkg::*;

   localparam int NUM_IN = 2;
   localparam int CHAN_W = 1;
   localparam int EW     = CHAN_W + 10;

   logic              clk = 1'b0;
   logic              reset_n = 1'b1;
   logic [1:0]        in_valid, in_sop, in_eop, in_ready;
   logic [15:0]       in_data;
   logic              out_valid, out_sop, out_eop, proto_err, dbg_state;
   logic              out_ready = 1'b0;
   logic [7:0]        out_data;
   logic [CHAN_W-1:0] out_channel;

   logic [9:0]        src0_q[$];
   logic [9:0]        src1_q[$];
   logic [EW-1:0]     exp_q[$];
   int                total = 0;
   int                bad = 0;

   typedef struct {
      logic [1:0] v;
      logic [1:0] sop;
      bit         pre;
      int         pre_src;
      int         exp_first;
      int         exp_n;
      logic       exp_err;
   } vec_t;
   vec_t tbl[8];

   ddr2_sys_ddr2_dmaster_st_arbiter #(.NUM_IN(NUM_IN), .CHAN_W(CHAN_W)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .in_valid    (in_valid),
      .in_data     (in_data),
      .in_sop      (in_sop),
      .in_eop      (in_eop),
      .in_ready    (in_ready),
      .out_valid   (out_valid),
      .out_data    (out_data),
      .out_sop     (out_sop),
      .out_eop     (out_eop),
      .out_channel (out_channel),
      .out_ready   (out_ready),
      .proto_err   (proto_err),
      .dbg_state   (dbg_state)
   );

   // clock/reset
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: sim time expired, bad=%0d", bad);
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, got, want);
      end
   endtask

   // driver tasks
   task automatic push_beat(input int s, input logic [9:0] b);
      if (s == 0) src0_q.push_back(b);
      else        src1_q.push_back(b);
   endtask

   task automatic send_pkt(input int s, input int len, input logic [7:0] base);
      logic sop, eop;
      logic [7:0] d;
      for (int k = 0; k < len; k++) begin
         sop = (k == 0);
         eop = (k == len - 1);
         d   = base + 8'(k);
         push_beat(s, {sop, eop, d});
         exp_q.push_back({CHAN_W'(s), sop, eop, d});
      end
   endtask

   task automatic flush_src();
      src0_q.delete();
      src1_q.delete();
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2;
      reset_n = 1'b0;
      flush_src();
      exp_q.delete();
      out_ready = 1'b1;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic wait_drain(input string name, input int budget);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      check(name, exp_q.size(), 0);
   endtask

   // source drivers plus output scoreboard
   initial begin
      logic [1:0]    acc;
      logic [EW-1:0] got, want;
      in_valid = '0;
      in_sop   = '0;
      in_eop   = '0;
      in_data  = '0;
      forever begin
         @(negedge clk);
         acc = in_valid & in_ready;
         if (out_valid && out_ready) begin
            got = {out_channel, out_sop, out_eop, out_data};
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL out_beat: got %0h, nothing expected", got);
            end else begin
               want = exp_q.pop_front();
               if (got !== want) begin
                  bad++;
                  $display("FAIL out_beat: got %0h want %0h", got, want);
               end
            end
         end
         @(posedge clk);
         #1;
         if (acc[0] && src0_q.size() > 0) void'(src0_q.pop_front());
         if (acc[1] && src1_q.size() > 0) void'(src1_q.pop_front());
         in_valid = '0;
         in_sop   = '0;
         in_eop   = '0;
         in_data  = '0;
         if (src0_q.size() > 0) begin
            in_valid[0] = 1'b1;
            {in_sop[0], in_eop[0], in_data[7:0]} = src0_q[0];
         end
         if (src1_q.size() > 0) begin
            in_valid[1] = 1'b1;
            {in_sop[1], in_eop[1], in_data[15:8]} = src1_q[0];
         end
      end
   end

   initial begin
      tbl[0] = '{2'b01, 2'b01, 1'b0, 0, 0, 1, 1'b0};
      tbl[1] = '{2'b10, 2'b10, 1'b0, 0, 1, 1, 1'b0};
      tbl[2] = '{2'b11, 2'b11, 1'b0, 0, 0, 2, 1'b0};
      tbl[3] = '{2'b11, 2'b11, 1'b1, 0, 1, 2, 1'b0};
      tbl[4] = '{2'b11, 2'b11, 1'b1, 1, 0, 2, 1'b0};
      tbl[5] = '{2'b11, 2'b01, 1'b0, 0, 0, 1, 1'b1};
      tbl[6] = '{2'b11, 2'b10, 1'b1, 1, 1, 1, 1'b1};
      tbl[7] = '{2'b00, 2'b00, 1'b0, 0, 0, 0, 1'b0};

      // Idle out: asynchronous reset values, then 20 quiet cycles.
      #1 reset_n = 1'b0;
      #2 check("reset_vals", {out_valid, out_sop, out_eop, out_data, out_channel, in_ready, proto_err, dbg_state}, 0);
      @(negedge clk);
      reset_n = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         check("idle_quiet", {out_valid, out_sop, out_eop, out_data, out_channel, in_ready, proto_err, dbg_state}, 0);
      end

      // Single source, 3-byte packet.
      do_reset();
      @(negedge clk);
      send_pkt(1, 3, 8'hA0);
      @(negedge clk);
      check("sop_bubble", in_ready, 2'b00);
      @(negedge clk);
      check("ready_rise", in_ready, 2'b10);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("single_valid", out_valid, 1'b1);
         check("single_chan", out_channel, 1'b1);
      end
      @(negedge clk);
      check("single_ready_off", in_ready, 2'b00);
      check("single_out_off", out_valid, 1'b0);
      check("single_drain", exp_q.size(), 0);

      // Fairness: both sources, two 2-byte packets each.
      do_reset();
      @(negedge clk);
      send_pkt(0, 2, 8'h00);
      send_pkt(1, 2, 8'h10);
      send_pkt(0, 2, 8'h20);
      send_pkt(1, 2, 8'h30);
      wait_drain("fair_drain", 60);
      check("fair_no_err", proto_err, 1'b0);

      // Backpressure mid-packet.
      do_reset();
      @(negedge clk);
      send_pkt(0, 6, 8'h40);
      for (int n = 0; n < 40 && exp_q.size() > 3; n++) @(negedge clk);
      check("bp_reached", exp_q.size() <= 3 && exp_q.size() > 0, 1'b1);
      @(posedge clk);
      #1 out_ready = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         check("bp_valid", out_valid, 1'b1);
         if (exp_q.size() > 0) check("bp_hold", out_data, exp_q[0][7:0]);
         check("bp_ready", in_ready, 2'b00);
      end
      @(posedge clk);
      #1 out_ready = 1'b1;
      wait_drain("bp_drain", 30);

      // Single-beat packet from src0 while src1 waits.
      do_reset();
      @(negedge clk);
      send_pkt(0, 1, 8'h55);
      send_pkt(1, 2, 8'h60);
      wait_drain("sbeat_drain", 30);
      check("sbeat_state", dbg_state, ST_IDLE);

      // Arbitration vectors.
      for (int r = 0; r < 8; r++) begin
         do_reset();
         if (tbl[r].pre) begin
            @(negedge clk);
            send_pkt(tbl[r].pre_src, 1, 8'hE0 + 8'(tbl[r].pre_src));
            wait_drain("tbl_pre", 20);
         end
         @(negedge clk);
         for (int s = 0; s < 2; s++)
            if (tbl[r].v[s]) push_beat(s, {tbl[r].sop[s], 1'b1, 8'h10 + 8'(s)});
         if (tbl[r].exp_n >= 1)
            exp_q.push_back({CHAN_W'(tbl[r].exp_first), 1'b1, 1'b1, 8'h10 + 8'(tbl[r].exp_first)});
         if (tbl[r].exp_n == 2)
            exp_q.push_back({CHAN_W'(1 - tbl[r].exp_first), 1'b1, 1'b1, 8'h11 - 8'(tbl[r].exp_first)});
         repeat (12) @(negedge clk);
         check($sformatf("tbl%0d_drain", r), exp_q.size(), 0);
         check($sformatf("tbl%0d_err", r), proto_err, tbl[r].exp_err);
         flush_src();
         repeat (2) @(negedge clk);
      end

      // Protocol error, then reset mid-packet.
      do_reset();
      @(negedge clk);
      push_beat(1, {1'b0, 1'b0, 8'h77});
      repeat (4) @(negedge clk);
      check("err_flag", proto_err, 1'b1);
      check("err_no_grant", in_ready, 2'b00);
      check("err_no_out", out_valid, 1'b0);
      flush_src();
      repeat (2) @(negedge clk);
      send_pkt(0, 8, 8'h80);
      for (int n = 0; n < 40 && exp_q.size() > 5; n++) @(negedge clk);
      check("mid_reached", out_valid, 1'b1);
      #2 reset_n = 1'b0;
      flush_src();
      exp_q.delete();
      #1 check("async_reset", {out_valid, out_sop, out_eop, out_data, out_channel, in_ready, proto_err, dbg_state}, 0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      send_pkt(1, 2, 8'h90);
      wait_drain("post_reset_drain", 30);
      check("post_reset_err", proto_err, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
